// File: rtl/control_pkg.sv
// Shared definitions for the multicycle ARM-subset control unit.
// Contents:
//   ctrl_state_t - FSM state encoding
//   ALU_*        - ALUControl encodings
//   OP_*         - Instr[27:26] instruction class encodings
//   CMD_*        - data-processing cmd field (Instr[24:21]) opcodes
package control_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRd,
        StMemWb,
        StMemWr,
        StExeR,
        StExeI,
        StAluWb,
        StBranch,
        StUndef
    } ctrl_state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] OP_DP     = 2'b00;
    localparam logic [1:0] OP_MEM    = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;
    localparam logic [1:0] OP_UNDEF  = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

endpackage

// File: rtl/condition_eval.sv
// ARM condition-code evaluation (purely combinational).
// Ports:
//   cond_i    - instruction condition field Instr[31:28]
//   flags_i   - registered {N,Z,C,V}
//   cond_ex_o - 1 when the instruction should commit its writes
module condition_eval (
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_o
);

    logic n, z, c, v;

    always_comb begin
        {n, z, c, v} = flags_i;
        cond_ex_o    = 1'b0;
        case (cond_i)
            4'b0000: cond_ex_o = z;                // EQ
            4'b0001: cond_ex_o = ~z;               // NE
            4'b0010: cond_ex_o = c;                // CS
            4'b0011: cond_ex_o = ~c;               // CC
            4'b0100: cond_ex_o = n;                // MI
            4'b0101: cond_ex_o = ~n;               // PL
            4'b0110: cond_ex_o = v;                // VS
            4'b0111: cond_ex_o = ~v;               // VC
            4'b1000: cond_ex_o = c & ~z;           // HI
            4'b1001: cond_ex_o = ~c | z;           // LS
            4'b1010: cond_ex_o = (n == v);         // GE
            4'b1011: cond_ex_o = (n != v);         // LT
            4'b1100: cond_ex_o = ~z & (n == v);    // GT
            4'b1101: cond_ex_o = z | (n != v);     // LE
            4'b1110: cond_ex_o = 1'b1;             // AL
            default: cond_ex_o = 1'b0;             // 1111: never commits
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control unit for the ARM-subset processor.
// Sequences the shared datapath, holds the NZCV flag register and gates all
// architectural writes with the instruction's condition.
// Ports:
//   clk, rst_n              - clock, synchronous active-low reset
//   Cond, Op, Funct, Rd     - instruction fields from the IR
//   ALUFlags                - {N,Z,C,V} from the ALU
//   MemReady                - memory completed the current access
//   PCWrite/RegWrite/MemWrite/IRWrite - write enables
//   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc - datapath selects
//   Flags                   - registered NZCV
//   InstrDone               - pulse in an instruction's final cycle
module multicycle_controller
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] Flags,
    output logic       InstrDone
);

    ctrl_state_t state_q, state_d;
    logic [3:0]  flags_q, flags_d;
    logic        cond_ex_q, cond_ex_d;
    logic        cond_ex;

    logic [1:0]  dp_alu_ctrl;
    logic        no_write;
    logic [1:0]  flag_w;

    logic        pc_we, reg_we, mem_we, ir_we, done;
    logic        is_exe, is_wb;

    condition_eval u_condition_eval (
        .cond_i    (Cond),
        .flags_i   (flags_q),
        .cond_ex_o (cond_ex)
    );

    // Data-processing decode from the cmd and S fields.
    always_comb begin
        dp_alu_ctrl = ALU_ADD;
        no_write    = 1'b0;
        flag_w      = 2'b00;
        case (Funct[4:1])
            CMD_ADD: begin
                dp_alu_ctrl = ALU_ADD;
                flag_w      = {Funct[0], Funct[0]};
            end
            CMD_SUB: begin
                dp_alu_ctrl = ALU_SUB;
                flag_w      = {Funct[0], Funct[0]};
            end
            CMD_AND: begin
                dp_alu_ctrl = ALU_AND;
                flag_w      = {Funct[0], 1'b0};
            end
            CMD_ORR: begin
                dp_alu_ctrl = ALU_ORR;
                flag_w      = {Funct[0], 1'b0};
            end
            CMD_CMP: begin
                // Compare always sets all flags and never writes a register.
                dp_alu_ctrl = ALU_SUB;
                no_write    = 1'b1;
                flag_w      = 2'b11;
            end
            default: begin
                no_write = 1'b1;
                flag_w   = 2'b00;
            end
        endcase
    end

    assign is_exe = (state_q == StExeR) || (state_q == StExeI);
    assign is_wb  = (state_q == StMemWb) || (state_q == StAluWb);

    // Condition is frozen at the end of DECODE so the writeback sees the
    // pre-execute flags even though EXE may have updated them.
    assign cond_ex_d = (state_q == StDecode) ? cond_ex : cond_ex_q;

    always_comb begin
        flags_d = flags_q;
        if (is_exe && cond_ex_q) begin
            if (flag_w[1]) flags_d[3:2] = ALUFlags[3:2];
            if (flag_w[0]) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

    // Next state and Moore-style output decode.
    always_comb begin
        state_d    = state_q;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        done       = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;

        unique case (state_q)
            StFetch: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (MemReady) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (Op)
                    OP_MEM:    state_d = StMemAdr;
                    OP_BRANCH: state_d = StBranch;
                    OP_DP:     state_d = Funct[5] ? StExeI : StExeR;
                    default:   state_d = StUndef;
                endcase
            end
            StMemAdr: begin
                ALUSrcB = 2'b01;
                state_d = Funct[0] ? StMemRd : StMemWr;
            end
            StMemRd: begin
                AdrSrc = 1'b1;
                if (MemReady) state_d = StMemWb;
            end
            StMemWr: begin
                AdrSrc = 1'b1;
                mem_we = cond_ex_q;
                if (MemReady) begin
                    done    = 1'b1;
                    state_d = StFetch;
                end
            end
            StExeR: begin
                ALUSrcB    = 2'b00;
                ALUControl = dp_alu_ctrl;
                state_d    = StAluWb;
            end
            StExeI: begin
                ALUSrcB    = 2'b01;
                ALUControl = dp_alu_ctrl;
                state_d    = StAluWb;
            end
            StMemWb, StAluWb: begin
                ResultSrc = (state_q == StMemWb) ? 2'b01 : 2'b00;
                done      = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pc_we     = cond_ex_q;
                done      = 1'b1;
                state_d   = StFetch;
            end
            StUndef: begin
                done    = 1'b1;
                state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase

        // Writes to R15 redirect the PC instead of the register file.
        if (is_wb) begin
            if (Rd == 4'd15) pc_we  = cond_ex_q;
            else             reg_we = cond_ex_q & ~no_write;
        end
    end

    assign PCWrite   = pc_we & rst_n;
    assign RegWrite  = reg_we & rst_n;
    assign MemWrite  = mem_we & rst_n;
    assign IRWrite   = ir_we & rst_n;
    assign InstrDone = done & rst_n;

    assign ImmSrc = Op;
    assign RegSrc = {Op == OP_MEM, Op == OP_BRANCH};
    assign Flags  = flags_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: a table of whole-instruction
// vectors (cycle count, write-enable counts, final flags, one control probe)
// plus hand-written reset and decode sequences.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       MemReady;
    logic       PCWrite, RegWrite, MemWrite, IRWrite;
    logic       AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc;
    logic [3:0] Flags;
    logic       InstrDone;

    int errors = 0;
    int checks = 0;

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .Flags      (Flags),
        .InstrDone  (InstrDone)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rd;
        logic [3:0]  alu_flags;
        logic [15:0] ready;     // MemReady per cycle index of the instruction
        int          cycles;
        int          regw;
        int          pcw;
        int          memw;
        logic [3:0]  flags;     // Flags after the instruction
        int          probe_idx;
        logic [7:0]  probe;     // {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input string name, input logic [3:0] cond, input logic [1:0] op,
                                input logic [5:0] funct, input logic [3:0] rd,
                                input logic [3:0] alu_flags, input logic [15:0] ready,
                                input int cycles, input int regw, input int pcw, input int memw,
                                input logic [3:0] flags, input int probe_idx,
                                input logic [7:0] probe);
        vec_t v;
        v.name = name; v.cond = cond; v.op = op; v.funct = funct; v.rd = rd;
        v.alu_flags = alu_flags; v.ready = ready; v.cycles = cycles; v.regw = regw;
        v.pcw = pcw; v.memw = memw; v.flags = flags; v.probe_idx = probe_idx; v.probe = probe;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Entered and left at a falling edge with the DUT in FETCH.
    task automatic run_vec(input vec_t v);
        int         cyc = 0;
        int         rw = 0, pw = 0, mw = 0, iw = 0;
        logic       done = 1'b0;
        logic [7:0] pr = 8'h00;
        logic [3:0] idx;
        Cond = v.cond; Op = v.op; Funct = v.funct; Rd = v.rd; ALUFlags = v.alu_flags;
        while (!done && cyc < 16) begin
            idx      = cyc[3:0];
            MemReady = v.ready[idx];
            #1;
            rw += int'(RegWrite);
            pw += int'(PCWrite);
            mw += int'(MemWrite);
            iw += int'(IRWrite);
            if (cyc == v.probe_idx) pr = {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl};
            done = InstrDone;
            @(negedge clk);
            cyc++;
        end
        chk({v.name, " done_seen"}, int'(done), 1);
        chk({v.name, " cycles"}, cyc, v.cycles);
        chk({v.name, " regwrite"}, rw, v.regw);
        chk({v.name, " pcwrite"}, pw, v.pcw);
        chk({v.name, " memwrite"}, mw, v.memw);
        chk({v.name, " irwrite"}, iw, 1);
        chk({v.name, " flags"}, int'(Flags), int'(v.flags));
        chk({v.name, " probe"}, int'(pr), int'(v.probe));
        if (!done) begin
            // Resynchronise to FETCH after a lost instruction.
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end
    endtask

    initial begin
        vecs[0]  = mk("add_s",     4'hE, 2'b00, 6'b001001, 4'd1,  4'b0100, 16'hFFFF,
                      4, 1, 1, 0, 4'b0100, 2, 8'b00000000);
        vecs[1]  = mk("b_ne_nt",   4'h1, 2'b10, 6'b000000, 4'd0,  4'b0000, 16'hFFFF,
                      3, 0, 1, 0, 4'b0100, 2, 8'b00011000);
        vecs[2]  = mk("b_eq_t",    4'h0, 2'b10, 6'b000000, 4'd0,  4'b0000, 16'hFFFF,
                      3, 0, 2, 0, 4'b0100, 2, 8'b00011000);
        vecs[3]  = mk("cmp",       4'hE, 2'b00, 6'b010100, 4'd0,  4'b0110, 16'hFFFF,
                      4, 0, 1, 0, 4'b0110, 2, 8'b00000001);
        vecs[4]  = mk("ldr_stall", 4'hE, 2'b01, 6'b011001, 4'd2,  4'b1111, 16'hFFE7,
                      7, 1, 1, 0, 4'b0110, 6, 8'b00000100);
        vecs[5]  = mk("str",       4'hE, 2'b01, 6'b011000, 4'd2,  4'b1111, 16'hFFFF,
                      4, 0, 1, 1, 4'b0110, 3, 8'b10000000);
        vecs[6]  = mk("add_pc",    4'hE, 2'b00, 6'b001000, 4'd15, 4'b0000, 16'hFFFF,
                      4, 0, 2, 0, 4'b0110, 1, 8'b01100000);
        vecs[7]  = mk("undef",     4'hE, 2'b11, 6'b001001, 4'd1,  4'b1111, 16'hFFFF,
                      3, 0, 1, 0, 4'b0110, 2, 8'b00000000);
        vecs[8]  = mk("add_nv",    4'hF, 2'b00, 6'b001001, 4'd1,  4'b1001, 16'hFFFF,
                      4, 0, 1, 0, 4'b0110, 2, 8'b00000000);
        vecs[9]  = mk("orr_imm",   4'hE, 2'b00, 6'b111001, 4'd4,  4'b1011, 16'hFFFF,
                      4, 1, 1, 0, 4'b1010, 2, 8'b00010011);
        vecs[10] = mk("add_ge_nt", 4'hA, 2'b00, 6'b001001, 4'd1,  4'b0000, 16'hFFFF,
                      4, 0, 1, 0, 4'b1010, 2, 8'b00000000);
        vecs[11] = mk("add_fstl",  4'hE, 2'b00, 6'b001000, 4'd3,  4'b0101, 16'hFFFE,
                      5, 1, 1, 0, 4'b1010, 0, 8'b01101000);
        vecs[12] = mk("str_stall", 4'hE, 2'b01, 6'b011000, 4'd5,  4'b0000, 16'hFFF7,
                      5, 0, 1, 2, 4'b1010, 2, 8'b00010000);
        vecs[13] = mk("eor_nop",   4'hE, 2'b00, 6'b000011, 4'd6,  4'b0101, 16'hFFFF,
                      4, 0, 1, 0, 4'b1010, 3, 8'b00000000);
        vecs[14] = mk("sub_lt",    4'hB, 2'b00, 6'b000101, 4'd7,  4'b0011, 16'hFFFF,
                      4, 1, 1, 0, 4'b0011, 2, 8'b00000001);
        vecs[15] = mk("b_post_rst", 4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, 16'hFFFF,
                      3, 0, 1, 0, 4'b0000, 2, 8'b00011000);

        // Reset behaviour and combinational ImmSrc/RegSrc.
        rst_n = 1'b0; Cond = 4'hE; Op = 2'b10; Funct = 6'b0; Rd = 4'd0;
        ALUFlags = 4'b0; MemReady = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst irwrite", int'(IRWrite), 0);
        chk("rst pcwrite", int'(PCWrite), 0);
        chk("immsrc b", int'(ImmSrc), 2);
        chk("regsrc b", int'(RegSrc), 1);
        Op = 2'b01;
        #1;
        chk("regsrc mem", int'(RegSrc), 2);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel flags", int'(Flags), 0);
        chk("rel irwrite", int'(IRWrite), 1);
        chk("rel alusrcb", int'(ALUSrcB), 2);
        @(negedge clk);
        // The FETCH above advanced; finish that instruction as an undefined op.
        Op = 2'b11;
        @(negedge clk);
        #1;
        chk("rel undef done", int'(InstrDone), 1);
        @(negedge clk);

        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // Reset while a store is stalled in MEMWR.
        Cond = 4'hE; Op = 2'b01; Funct = 6'b011000; Rd = 4'd1; MemReady = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge clk);
        MemReady = 1'b0;
        #1;
        chk("memwr stall memwrite", int'(MemWrite), 1);
        chk("memwr stall done", int'(InstrDone), 0);
        rst_n = 1'b0;
        #1;
        chk("memwr rst memwrite", int'(MemWrite), 0);
        chk("memwr rst done", int'(InstrDone), 0);
        @(negedge clk);
        rst_n = 1'b1;
        MemReady = 1'b1;
        #1;
        chk("post rst flags", int'(Flags), 0);
        chk("post rst fetch ir", int'(IRWrite), 1);
        chk("post rst fetch srca", int'(ALUSrcA), 1);
        MemReady = 1'b0;  // hold FETCH until the next vector starts
        @(negedge clk);
        run_vec(vecs[15]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
